// File: rtl/serial_eq_driver.sv
// ---------------------------------------------------------------------------
// serial_eq_driver
//
// Initiator side of a bit-serial word equality check. Two WIDTH-bit words are
// captured through a valid/ready handshake. They are then presented LSB-first,
// one bit pair per clock, to an external combinational 1-bit comparator. The
// comparator's verdict (c_in) is sampled every SHIFT cycle. The driver reports
// whether the words matched and where the first mismatch occurred.
//
// Ports:
//   clk          in   system clock, rising-edge active
//   rst          in   asynchronous active-high reset
//   start_valid  in   request to compare word_a against word_b
//   start_ready  out  high only in IDLE; handshake = start_valid && start_ready
//   word_a       in   [WIDTH-1:0] first operand, captured at the handshake
//   word_b       in   [WIDTH-1:0] second operand, captured at the handshake
//   a_bit        out  current serial bit of word_a (0 outside SHIFT)
//   b_bit        out  current serial bit of word_b (0 outside SHIFT)
//   c_in         in   comparator result, 1 = current bits equal
//   busy         out  high in SHIFT and DONE
//   done         out  one-cycle pulse when the result becomes valid
//   equal        out  1 when every bit pair matched; held until next handshake
//   mismatch_idx out  [IDXW-1:0] lowest mismatching bit index, 0 when equal
//
// Timing: handshake at edge k -> SHIFT cycles k..k+WIDTH-1 -> done in cycle
// k+WIDTH -> start_ready again in cycle k+WIDTH+1.
// ---------------------------------------------------------------------------
module serial_eq_driver #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] word_a,
    input  logic [WIDTH-1:0] word_b,
    output logic             a_bit,
    output logic             b_bit,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [IDXW-1:0]  mismatch_idx
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] CNT_LAST = IDXW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] sh_a_reg;
    logic [WIDTH-1:0] sh_b_reg;
    logic [WIDTH-1:0] sh_a_next;
    logic [WIDTH-1:0] sh_b_next;
    logic [IDXW-1:0]  cnt_reg;
    logic             equal_reg;
    logic [IDXW-1:0]  mismatch_idx_reg;

    // Right-shift by one with zero fill: the next LSB to present moves into
    // bit 0 while the vacated MSB is cleared.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == WIDTH - 1) begin : g_msb
                assign sh_a_next[gi] = 1'b0;
                assign sh_b_next[gi] = 1'b0;
            end else begin : g_mid
                assign sh_a_next[gi] = sh_a_reg[gi + 1];
                assign sh_b_next[gi] = sh_b_reg[gi + 1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            sh_a_reg         <= '0;
            sh_b_reg         <= '0;
            cnt_reg          <= '0;
            equal_reg        <= 1'b0;
            mismatch_idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_valid) begin
                        sh_a_reg         <= word_a;
                        sh_b_reg         <= word_b;
                        cnt_reg          <= '0;
                        equal_reg        <= 1'b1;
                        mismatch_idx_reg <= '0;
                        state_reg        <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // equal_reg still high means no mismatch has been recorded
                    // yet in this run, so only the first failing index is kept.
                    if (!c_in && equal_reg) begin
                        equal_reg        <= 1'b0;
                        mismatch_idx_reg <= cnt_reg;
                    end
                    sh_a_reg <= sh_a_next;
                    sh_b_reg <= sh_b_next;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + IDXW'(1);
                    end
                end

                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded directly from flops; nothing passes through
    // combinationally from an input.
    assign start_ready  = (state_reg == ST_IDLE);
    assign busy         = (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
    assign done         = (state_reg == ST_DONE);
    assign a_bit        = (state_reg == ST_SHIFT) && sh_a_reg[0];
    assign b_bit        = (state_reg == ST_SHIFT) && sh_b_reg[0];
    assign equal        = equal_reg;
    assign mismatch_idx = mismatch_idx_reg;

endmodule

// File: tb/tb_serial_eq_driver.sv
module tb_serial_eq_driver;

    localparam int WIDTH = 8;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] word_a;
    logic [WIDTH-1:0] word_b;
    logic             a_bit;
    logic             b_bit;
    logic             c_in;
    logic             busy;
    logic             done;
    logic             equal;
    logic [IDXW-1:0]  mismatch_idx;

    int tests_run;
    int tests_failed;

    serial_eq_driver #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .word_a       (word_a),
        .word_b       (word_b),
        .a_bit        (a_bit),
        .b_bit        (b_bit),
        .c_in         (c_in),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_idx (mismatch_idx)
    );

    // External 1-bit comparator cell.
    assign c_in = ~(a_bit ^ b_bit);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             exp_equal;
        logic [IDXW-1:0]  exp_idx;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at the negedge of SHIFT cycle 0; returns at the negedge of DONE.
    task automatic shift_check(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int i = 0; i < WIDTH; i++) begin
            check($sformatf("a_bit[%0d]", i), {31'd0, a_bit}, {31'd0, a[i]});
            check($sformatf("b_bit[%0d]", i), {31'd0, b_bit}, {31'd0, b[i]});
            check($sformatf("shift_busy[%0d]", i), {31'd0, busy}, 32'd1);
            check($sformatf("shift_ready[%0d]", i), {31'd0, start_ready}, 32'd0);
            check($sformatf("shift_done[%0d]", i), {31'd0, done}, 32'd0);
            @(negedge clk);
        end
    endtask

    // Called at the negedge of DONE; returns at the negedge of the next IDLE.
    task automatic done_check(input logic exp_eq, input logic [IDXW-1:0] exp_idx);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_ready", {31'd0, start_ready}, 32'd0);
        check("done_a_bit", {31'd0, a_bit}, 32'd0);
        check("done_b_bit", {31'd0, b_bit}, 32'd0);
        check("equal", {31'd0, equal}, {31'd0, exp_eq});
        check("mismatch_idx", {29'd0, mismatch_idx}, {29'd0, exp_idx});
        @(negedge clk);
        check("idle_done_low", {31'd0, done}, 32'd0);
        check("idle_ready", {31'd0, start_ready}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("equal_held", {31'd0, equal}, {31'd0, exp_eq});
        check("idx_held", {29'd0, mismatch_idx}, {29'd0, exp_idx});
    endtask

    task automatic do_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic exp_eq, input logic [IDXW-1:0] exp_idx);
        int n;
        n = 0;
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", {31'd0, start_ready}, 32'd1);
        word_a      = a;
        word_b      = b;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        shift_check(a, b);
        $display("[TB] compare a=%02h b=%02h -> equal=%0b idx=%0d (expect %0b/%0d)",
                 a, b, equal, mismatch_idx, exp_eq, exp_idx);
        done_check(exp_eq, exp_idx);
    endtask

    initial begin
        bit seen_done;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start_valid  = 1'b0;
        word_a       = '0;
        word_b       = '0;

        vecs[0] = '{8'hA5, 8'hA5, 1'b1, 3'd0};
        vecs[1] = '{8'h0F, 8'h0B, 1'b0, 3'd2};
        vecs[2] = '{8'h80, 8'h00, 1'b0, 3'd7};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 3'd0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 3'd0};
        vecs[5] = '{8'h60, 8'h20, 1'b0, 3'd6};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_equal", {31'd0, equal}, 32'd0);
        check("rst_idx", {29'd0, mismatch_idx}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, start_ready}, 32'd1);
        check("rst_a_bit", {31'd0, a_bit}, 32'd0);
        check("rst_b_bit", {31'd0, b_bit}, 32'd0);
        $display("[TB] reset state checked");

        // Table-driven compares
        for (int v = 0; v < 6; v++) begin
            do_compare(vecs[v].a, vecs[v].b, vecs[v].exp_equal, vecs[v].exp_idx);
        end

        // start_valid held high through SHIFT with changing operands
        word_a      = 8'h12;
        word_b      = 8'h16;
        start_valid = 1'b1;
        @(negedge clk);
        word_a = 8'h34;
        word_b = 8'h34;
        shift_check(8'h12, 8'h16);
        $display("[TB] held-valid first run a=12 b=16 -> equal=%0b idx=%0d", equal, mismatch_idx);
        done_check(1'b0, 3'd2);
        // start_valid still high: the IDLE cycle just checked captures 34/34
        @(negedge clk);
        start_valid = 1'b0;
        shift_check(8'h34, 8'h34);
        $display("[TB] held-valid second run a=34 b=34 -> equal=%0b idx=%0d", equal, mismatch_idx);
        done_check(1'b1, 3'd0);

        // Reset in the 4th SHIFT cycle aborts the run
        word_a      = 8'h0F;
        word_b      = 8'h0F;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_a_bit", {31'd0, a_bit}, 32'd1);
        check("abort_pre_equal", {31'd0, equal}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'd0, start_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_equal", {31'd0, equal}, 32'd0);
        check("abort_idx", {29'd0, mismatch_idx}, 32'd0);
        check("abort_a_bit", {31'd0, a_bit}, 32'd0);
        check("abort_b_bit", {31'd0, b_bit}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        $display("[TB] reset abort during SHIFT checked");
        do_compare(8'h3C, 8'h3C, 1'b1, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_eq_driver.md
Name: serial_eq_driver

Overview:
Initiator side of the 1-bit equality comparator interface. It accepts two WIDTH-bit words through a valid/ready handshake and serialises them LSB-first as bit pairs (a_bit, b_bit), one pair per clock, into an external combinational 1-bit comparator. It samples the comparator's result (c_in) each cycle and reports word equality and the index of the first mismatching bit. This lets one 1-bit comparator cell check full words in WIDTH cycles.

Parameters:
WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
IDXW, $clog2(WIDTH), width of the bit counter and of mismatch_idx; derived, never overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
start_valid  input  1  request to compare word_a against word_b.
start_ready  output  1  high only in IDLE; the handshake completes when start_valid && start_ready at a rising edge.
word_a  input  WIDTH  first operand; sampled only at the handshake.
word_b  input  WIDTH  second operand; sampled only at the handshake.
a_bit  output  1  serial bit of word_a to the comparator.
b_bit  output  1  serial bit of word_b to the comparator.
c_in  input  1  comparator result; 1 means the current bits are equal. Sampled combinationally in the same cycle.
busy  output  1  high in SHIFT and DONE.
done  output  1  one-cycle pulse; the result is valid from this cycle onward.
equal  output  1  1 when all WIDTH bit pairs matched; held until the next handshake.
mismatch_idx  output  IDXW  lowest bit index where c_in was 0; 0 when equal=1; held until the next handshake.

Behaviour:
- States: IDLE, SHIFT, DONE. State, shift registers, counter, equal and mismatch_idx are flops.
- Reset (async assert, any state):
  - state=IDLE, counter=0, shift registers=0.
  - equal=0, mismatch_idx=0, done=0, busy=0.
  - a_bit=b_bit=0; start_ready=1.
  - Any comparison in progress is aborted and no done pulse is produced.
- IDLE:
  - start_ready=1.
  - On handshake: load sh_a<=word_a, sh_b<=word_b, cnt<=0, equal<=1, mismatch_idx<=0, then go to SHIFT.
- SHIFT:
  - a_bit=sh_a[0], b_bit=sh_b[0]; start_ready=0, and start_valid is ignored.
  - Each edge: if c_in==0 and no mismatch has been recorded yet, equal<=0 and mismatch_idx<=cnt (first mismatch only). Then shift both registers right by one and cnt<=cnt+1.
  - When cnt==WIDTH-1 is sampled, go to DONE. SHIFT therefore lasts exactly WIDTH cycles.
- DONE (exactly one cycle):
  - done=1, busy=1, a_bit=b_bit=0.
  - Next state is IDLE unconditionally; a handshake cannot occur in DONE.
- Outside SHIFT, a_bit and b_bit are driven 0.
- Latency: handshake at edge k → SHIFT cycles k..k+WIDTH-1 → done high in cycle k+WIDTH → start_ready high again the cycle after. Back-to-back throughput is one word per WIDTH+2 cycles.
- c_in is not registered internally. The comparator must settle within one cycle after a_bit/b_bit change.
- start_valid may stay high continuously; a new handshake occurs on the first IDLE cycle.

Test Plan:
1. WIDTH=8, after reset: check equal=0, mismatch_idx=0, done=0, start_ready=1, a_bit=b_bit=0. Then word_a=word_b=8'hA5 → a_bit sequence 1,0,1,0,0,1,0,1; done 8 cycles after the handshake; equal=1, mismatch_idx=0.
2. word_a=8'h0F, word_b=8'h0B → equal=0, mismatch_idx=2.
3. word_a=8'h80, word_b=8'h00 → equal=0, mismatch_idx=7, checking the last-bit boundary. Then word_a=8'hFF, word_b=8'h00 → mismatch_idx=0, confirming only the first mismatch is recorded.
4. start_valid held high with new operands during SHIFT → no second capture. After done, the next IDLE cycle captures the new words, and results from the prior run are held until then.
5. Assert rst in the 4th SHIFT cycle → immediate IDLE with outputs at reset values and no done pulse. A subsequent 8'h3C vs 8'h3C compare completes with equal=1.
